pmem_responder: RTL and testbench
=================================

Name: pmem_responder

Overview:
- Responder end of the physical-memory line interface driven by the core's arbiter.
- Accepts one read or write request at a time and serves a full 128-bit cache line after a fixed, parameterised latency.
- Pulses a one-cycle response on completion.
- Stands in for DRAM in system simulation and FPGA builds, behind the arbiter's pmem_* port set.

Parameters:
- DEPTH_LOG2, 12, log2 of line count; the store holds 2**DEPTH_LOG2 lines of 16 bytes (default covers the full 64 KB space).
- LATENCY, 4, cycles from request acceptance to pmem_resp; legal range 1..255.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous reset, active low
- pmem_read  in  1  line read request, held high until pmem_resp
- pmem_write  in  1  line write request, held high until pmem_resp
- pmem_address  in  16  byte address (lc3b_word); bits [3:0] ignored
- pmem_wdata  in  128  write line (lc3b_c_block)
- pmem_resp  out  1  one-cycle completion pulse
- pmem_rdata  out  128  read line (lc3b_c_block), registered
- busy  out  1  high while a request is in flight (states BUSY, RESP)
- protocol_err  out  1  sticky error flag, cleared only by reset

Behaviour:
- States: IDLE, BUSY, RESP.
- Reset (async, rst_n low) forces:
  - state=IDLE, pmem_resp=0, pmem_rdata=0, busy=0, protocol_err=0, latency counter=0.
  - Line store contents are NOT reset.
  - Reset mid-request aborts the request: no store update, no resp.
- IDLE:
  - On a rising edge with pmem_read|pmem_write high, accept the request.
  - Capture the operation, line index = pmem_address[DEPTH_LOG2+3:4] and pmem_wdata.
  - Load counter=LATENCY-1, then go to BUSY; if LATENCY==1, go directly to RESP.
- Index width and wrap:
  - Upper address bits above DEPTH_LOG2+3 are dropped, so the index wraps modulo the depth.
- BUSY:
  - Decrement the counter each cycle; when it reaches 0, go to RESP.
- RESP:
  - pmem_resp=1 for exactly this cycle. Accept at cycle t gives resp at cycle t+LATENCY.
  - Read: pmem_rdata holds store[index] during the RESP cycle, and keeps that value until the next read's RESP.
  - Write: store[index] <= captured wdata at the end of the RESP cycle. pmem_rdata is unchanged.
  - Next state is always IDLE.
- Back-to-back requests:
  - A request present in the cycle after RESP is treated as new. The minimum inter-resp spacing is LATENCY+1 cycles.
- Both read and write high at acceptance: treat as write and set protocol_err.
- Request dropped (read and write both low) while in BUSY: complete the operation anyway and set protocol_err.
- pmem_address line index differs from the captured index while in BUSY: ignore the change (the captured value is used) and set protocol_err.
- Operation flips read<->write while in BUSY: set protocol_err.
- Read-after-write to the same line returns the newly written data.
- Captured values only: no combinational path from inputs to pmem_resp or pmem_rdata.

Decomposition:
- Add to the lc3b_types package:
  - lc3b_pmem_state enum (IDLE, BUSY, RESP).
  - constant LC3B_LINE_OFFSET_BITS=4.
  - Reuse lc3b_word and lc3b_c_block.
- Sub-module pmem_array:
  - Parameter DEPTH_LOG2.
  - Synchronous write port; synchronous read port registered into pmem_rdata.
  - Single read/write address.
  - Keeps the store inferable as block RAM.
- FSM and counter live in pmem_responder.

Test Plan:
1. Reset, LATENCY=4: write 0x0123_4567_89AB_CDEF_0011_2233_4455_6677 to address 0x1230 -> resp high exactly 4 cycles after accept for one cycle. Then read 0x123E -> same line returned on the resp cycle; protocol_err=0.
2. LATENCY=1: read, immediately write, then read to line 0x0040 -> resps spaced exactly 2 cycles apart; the final read returns the written data.
3. Both read and write high, address 0x0200 -> treated as write, store updated, protocol_err=1 and still 1 after 10 idle cycles.
4. Assert read to 0x0500, change address to 0x0600 in BUSY -> line 0x0500 data returned, protocol_err=1.
5. Write 0xAAAA.. to 0x0300, assert rst_n low in BUSY, release, read 0x0300 -> resp never seen for the aborted write; read returns the old contents; pmem_rdata=0 immediately after reset.
6. DEPTH_LOG2=4: write to 0x0010, read 0x0110 -> aliases to the same line, returns the written data.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b types used by the memory-side blocks: word, cache line,
// physical-memory responder states and the line offset width.
package lc3b_types;

   typedef logic [15:0]  lc3b_word;
   typedef logic [127:0] lc3b_c_block;

   localparam int LC3B_LINE_OFFSET_BITS = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } lc3b_pmem_state;

endpackage

// File: rtl/pmem_array.sv
// Line store for the physical-memory responder: one shared address,
// synchronous write, synchronous read registered straight into the output.
module pmem_array #(
   parameter int DEPTH_LOG2 = 12
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DEPTH_LOG2-1:0] i_addr,
   input  logic                  i_we,
   input  logic                  i_re,
   input  logic [127:0]          i_wdata,
   output logic [127:0]          o_rdata
);
   import lc3b_types::*;

   lc3b_c_block r_mem [2**DEPTH_LOG2];

   // Store contents survive reset so the array stays inferable as block RAM.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_addr] <= i_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_rdata <= '0;
      end else if (i_re) begin
         o_rdata <= r_mem[i_addr];
      end
   end

endmodule

// File: rtl/pmem_responder.sv
// Responder end of the pmem line interface: serves one 128-bit line per
// request after LATENCY cycles and pulses pmem_resp for one cycle.
module pmem_responder #(
   parameter int DEPTH_LOG2 = 12,
   parameter int LATENCY    = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         pmem_read,
   input  logic         pmem_write,
   input  logic [15:0]  pmem_address,
   input  logic [127:0] pmem_wdata,
   output logic         pmem_resp,
   output logic [127:0] pmem_rdata,
   output logic         busy,
   output logic         protocol_err
);
   import lc3b_types::*;

   localparam int             IDX_LO = LC3B_LINE_OFFSET_BITS;
   localparam int             IDX_HI = DEPTH_LOG2 + LC3B_LINE_OFFSET_BITS - 1;
   localparam logic [7:0]     LOAD   = 8'(LATENCY - 1);

   lc3b_pmem_state          r_state;
   logic [7:0]              r_count;
   logic                    r_isWrite;
   logic [DEPTH_LOG2-1:0]   r_index;
   lc3b_c_block             r_wdata;
   logic                    r_err;

   logic                    w_req;
   logic                    w_accept;
   logic                    w_goResp;
   logic                    w_opWrite;
   logic                    w_errNow;
   logic [DEPTH_LOG2-1:0]   w_inIndex;
   logic [DEPTH_LOG2-1:0]   w_arrayAddr;
   logic                    w_arrayRe;
   logic                    w_arrayWe;
   logic                    w_unusedAddr;

   assign w_req      = pmem_read | pmem_write;
   assign w_inIndex  = pmem_address[IDX_HI:IDX_LO];
   assign w_accept   = (r_state == IDLE) && w_req;
   assign w_unusedAddr = ^pmem_address;

   // The array read is issued on the edge that enters RESP, so rdata is valid
   // during the RESP cycle; with LATENCY==1 that is the accept edge itself.
   assign w_goResp    = ((r_state == BUSY) && (r_count == 8'd1)) ||
                        (w_accept && (LATENCY == 1));
   assign w_opWrite   = (r_state == IDLE) ? pmem_write : r_isWrite;
   assign w_arrayAddr = (r_state == IDLE) ? w_inIndex : r_index;
   assign w_arrayRe   = w_goResp && !w_opWrite;
   assign w_arrayWe   = (r_state == RESP) && r_isWrite;

   assign w_errNow = (w_accept && pmem_read && pmem_write) ||
                     ((r_state == BUSY) &&
                      (!w_req || (w_inIndex != r_index) ||
                       (w_req && (pmem_write != r_isWrite))));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_count   <= '0;
         r_isWrite <= 1'b0;
         r_index   <= '0;
         r_wdata   <= '0;
         r_err     <= 1'b0;
      end else begin
         if (w_errNow) begin
            r_err <= 1'b1;
         end
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_isWrite <= pmem_write;
                  r_index   <= w_inIndex;
                  r_wdata   <= pmem_wdata;
                  r_count   <= LOAD;
                  r_state   <= (LATENCY == 1) ? RESP : BUSY;
               end
            end
            BUSY: begin
               r_count <= r_count - 8'd1;
               if (r_count == 8'd1) begin
                  r_state <= RESP;
               end
            end
            RESP: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   pmem_array #(
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_array (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_addr  (w_arrayAddr),
      .i_we    (w_arrayWe),
      .i_re    (w_arrayRe),
      .i_wdata (r_wdata),
      .o_rdata (pmem_rdata)
   );

   assign pmem_resp    = (r_state == RESP);
   assign busy         = (r_state != IDLE);
   assign protocol_err = r_err;

endmodule

// File: tb/tb_pmem_responder.sv
// Scoreboard bench for pmem_responder: three instances (LATENCY 4, LATENCY 1,
// DEPTH_LOG2 4) share clock and reset; expected responses are queued at drive time.
module tb_pmem_responder;

   typedef struct {
      int           dut;
      int           expCyc;
      logic [127:0] data;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         rd    [3];
   logic         wr    [3];
   logic [15:0]  addr  [3];
   logic [127:0] wdata [3];
   logic         resp  [3];
   logic [127:0] rdata [3];
   logic         busy  [3];
   logic         perr  [3];

   int           cyc = 0;
   int           tests = 0;
   int           fails = 0;
   int           respCount   [3];
   int           lastRespCyc [3];
   int           nextAccept  [3];
   logic [127:0] lastRead    [3];
   exp_t         sbq [$];
   exp_t         monE;

   localparam logic [127:0] DATA_A = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
   localparam logic [127:0] DATA_B = 128'hB0B0_1111_2222_3333_4444_5555_6666_7777;
   localparam logic [127:0] DATA_C = 128'hC0C0_CAFE_0000_1234_5678_9ABC_DEF0_0505;
   localparam logic [127:0] DATA_D = 128'hD0D0_0606_0606_0606_0606_0606_0606_0606;
   localparam logic [127:0] DATA_E = 128'hE0E0_0303_1357_2468_ACE0_BDF1_0303_0303;
   localparam logic [127:0] DATA_F = 128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA;
   localparam logic [127:0] DATA_G = 128'h6666_0040_0000_0000_0000_0000_0000_0001;
   localparam logic [127:0] DATA_H = 128'h8888_0040_FFFF_EEEE_DDDD_CCCC_BBBB_AAAA;
   localparam logic [127:0] DATA_J = 128'h1234_0010_5A5A_A5A5_0F0F_F0F0_3C3C_C3C3;

   pmem_responder #(.DEPTH_LOG2(12), .LATENCY(4)) dutL4 (
      .clk(clk), .rst_n(rst_n), .pmem_read(rd[0]), .pmem_write(wr[0]),
      .pmem_address(addr[0]), .pmem_wdata(wdata[0]), .pmem_resp(resp[0]),
      .pmem_rdata(rdata[0]), .busy(busy[0]), .protocol_err(perr[0]));

   pmem_responder #(.DEPTH_LOG2(12), .LATENCY(1)) dutL1 (
      .clk(clk), .rst_n(rst_n), .pmem_read(rd[1]), .pmem_write(wr[1]),
      .pmem_address(addr[1]), .pmem_wdata(wdata[1]), .pmem_resp(resp[1]),
      .pmem_rdata(rdata[1]), .busy(busy[1]), .protocol_err(perr[1]));

   pmem_responder #(.DEPTH_LOG2(4), .LATENCY(3)) dutD4 (
      .clk(clk), .rst_n(rst_n), .pmem_read(rd[2]), .pmem_write(wr[2]),
      .pmem_address(addr[2]), .pmem_wdata(wdata[2]), .pmem_resp(resp[2]),
      .pmem_rdata(rdata[2]), .busy(busy[2]), .protocol_err(perr[2]));

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int latOf(input int d);
      return (d == 1) ? 1 : ((d == 2) ? 3 : 4);
   endfunction

   task automatic checkOutput(input string tag, input logic [127:0] observed,
                              input logic [127:0] expected);
      tests++;
      if (observed !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   // Every response pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      for (int d = 0; d < 3; d++) begin
         if (resp[d] === 1'b1) begin
            respCount[d]++;
            lastRespCyc[d] = cyc;
            if (sbq.size() == 0 || sbq[0].dut != d) begin
               checkOutput($sformatf("unexpected resp dut%0d", d), 128'd1, 128'd0);
            end else begin
               monE = sbq.pop_front();
               checkOutput($sformatf("resp cycle dut%0d", d), 128'(cyc), 128'(monE.expCyc));
               checkOutput($sformatf("rdata dut%0d", d), rdata[d], monE.data);
            end
         end
      end
   end

   task automatic applyReset();
      rst_n = 1'b0;
      for (int d = 0; d < 3; d++) begin
         rd[d] = 1'b0;
         wr[d] = 1'b0;
      end
      #1;
      for (int d = 0; d < 3; d++) begin
         checkOutput($sformatf("reset resp dut%0d", d),  128'(resp[d]), 128'd0);
         checkOutput($sformatf("reset rdata dut%0d", d), rdata[d], 128'd0);
         checkOutput($sformatf("reset busy dut%0d", d),  128'(busy[d]), 128'd0);
         checkOutput($sformatf("reset perr dut%0d", d),  128'(perr[d]), 128'd0);
         nextAccept[d] = 0;
         lastRead[d]   = '0;
      end
      sbq.delete();
      @(negedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic applyStimulus(input int d, input logic r, input logic w,
                                input logic [15:0] a, input logic [127:0] data,
                                input logic [127:0] expData,
                                input logic [15:0] midAddr, input logic midDrop);
      int   acceptEdge;
      int   start;
      int   n;
      exp_t e;
      rd[d]    = r;
      wr[d]    = w;
      addr[d]  = a;
      wdata[d] = data;
      acceptEdge = (cyc + 1 > nextAccept[d]) ? cyc + 1 : nextAccept[d];
      e.dut    = d;
      e.expCyc = acceptEdge + latOf(d) - 1;
      e.data   = (r && !w) ? expData : lastRead[d];
      if (r && !w) lastRead[d] = expData;
      nextAccept[d] = e.expCyc + 2;
      sbq.push_back(e);
      start = respCount[d];
      while (cyc < acceptEdge) begin
         @(negedge clk);
         #1;
      end
      addr[d] = midAddr;
      if (midDrop) begin
         rd[d] = 1'b0;
         wr[d] = 1'b0;
      end
      n = 0;
      while (respCount[d] == start && n < 400) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (respCount[d] == start) begin
         checkOutput($sformatf("resp timeout dut%0d", d), 128'd0, 128'd1);
         sbq.delete();
      end
      rd[d] = 1'b0;
      wr[d] = 1'b0;
   endtask

   task automatic abortWrite(input logic [15:0] a, input logic [127:0] data);
      wr[0]    = 1'b1;
      addr[0]  = a;
      wdata[0] = data;
      repeat (3) @(negedge clk);
      #1;
      checkOutput("abort in flight busy", 128'(busy[0]), 128'd1);
      rst_n = 1'b0;
      wr[0] = 1'b0;
      #1;
      checkOutput("abort rdata zero", rdata[0], 128'd0);
      checkOutput("abort busy", 128'(busy[0]), 128'd0);
      checkOutput("abort resp", 128'(resp[0]), 128'd0);
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      nextAccept[0] = 0;
      lastRead[0]   = '0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int rec;
      for (int d = 0; d < 3; d++) begin
         rd[d] = 1'b0;
         wr[d] = 1'b0;
         addr[d] = '0;
         wdata[d] = '0;
         respCount[d] = 0;
         lastRespCyc[d] = 0;
         nextAccept[d] = 0;
         lastRead[d] = '0;
      end
      @(negedge clk);
      #1;
      applyReset();

      applyStimulus(0, 1'b0, 1'b1, 16'h1230, DATA_A, '0, 16'h1230, 1'b0);
      @(negedge clk);
      #1;
      checkOutput("resp single cycle", 128'(resp[0]), 128'd0);
      applyStimulus(0, 1'b1, 1'b0, 16'h123E, '0, DATA_A, 16'h123E, 1'b0);
      checkOutput("perr clean", 128'(perr[0]), 128'd0);

      applyStimulus(0, 1'b1, 1'b1, 16'h0200, DATA_B, '0, 16'h0200, 1'b0);
      checkOutput("perr both high", 128'(perr[0]), 128'd1);
      repeat (10) @(negedge clk);
      #1;
      checkOutput("perr sticky", 128'(perr[0]), 128'd1);
      applyStimulus(0, 1'b1, 1'b0, 16'h0200, '0, DATA_B, 16'h0200, 1'b0);

      applyReset();
      applyStimulus(0, 1'b0, 1'b1, 16'h0500, DATA_C, '0, 16'h0500, 1'b0);
      applyStimulus(0, 1'b0, 1'b1, 16'h0600, DATA_D, '0, 16'h0600, 1'b0);
      checkOutput("perr before addr change", 128'(perr[0]), 128'd0);
      applyStimulus(0, 1'b1, 1'b0, 16'h0500, '0, DATA_C, 16'h0600, 1'b0);
      checkOutput("perr addr change", 128'(perr[0]), 128'd1);

      applyReset();
      applyStimulus(0, 1'b0, 1'b1, 16'h0300, DATA_E, '0, 16'h0300, 1'b0);
      abortWrite(16'h0300, DATA_F);
      repeat (8) @(negedge clk);
      #1;
      applyStimulus(0, 1'b1, 1'b0, 16'h0300, '0, DATA_E, 16'h0300, 1'b0);
      checkOutput("perr after abort", 128'(perr[0]), 128'd0);

      applyReset();
      applyStimulus(0, 1'b1, 1'b0, 16'h0300, '0, DATA_E, 16'h0300, 1'b1);
      checkOutput("perr dropped request", 128'(perr[0]), 128'd1);

      applyStimulus(1, 1'b0, 1'b1, 16'h0040, DATA_G, '0, 16'h0040, 1'b0);
      applyStimulus(1, 1'b1, 1'b0, 16'h0040, '0, DATA_G, 16'h0040, 1'b0);
      rec = lastRespCyc[1];
      applyStimulus(1, 1'b0, 1'b1, 16'h0040, DATA_H, '0, 16'h0040, 1'b0);
      checkOutput("lat1 spacing read-write", 128'(lastRespCyc[1] - rec), 128'd2);
      rec = lastRespCyc[1];
      applyStimulus(1, 1'b1, 1'b0, 16'h0040, '0, DATA_H, 16'h0040, 1'b0);
      checkOutput("lat1 spacing write-read", 128'(lastRespCyc[1] - rec), 128'd2);
      checkOutput("lat1 perr", 128'(perr[1]), 128'd0);

      applyStimulus(2, 1'b0, 1'b1, 16'h0010, DATA_J, '0, 16'h0010, 1'b0);
      applyStimulus(2, 1'b1, 1'b0, 16'h0110, '0, DATA_J, 16'h0110, 1'b0);
      checkOutput("alias perr", 128'(perr[2]), 128'd0);

      repeat (5) @(negedge clk);
      #1;
      checkOutput("scoreboard drained", 128'(sbq.size()), 128'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
